// File: rtl/wupr_bank_tracker.sv
// Per-bank write-peak tracker that turns refresh requests into auto/dummy refresh decisions.
// Optional skip counter output enabled by defining WUPR_BANK_TRACKER_STATS_EN.
module wupr_bank_tracker #(
  parameter int ROW_WIDTH = 16,
  parameter int N_SEG     = 16,
  parameter int N_BANK    = 4,
  localparam int SEG_BITS  = $clog2(N_SEG),
  localparam int OFF_BITS  = ROW_WIDTH - SEG_BITS,
  localparam int BANK_BITS = (N_BANK > 1) ? $clog2(N_BANK) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  input  logic [BANK_BITS-1:0] wr_bank,
  input  logic [ROW_WIDTH-1:0] wr_row,
  input  logic                 clr_valid,
  input  logic [BANK_BITS-1:0] clr_bank,
  input  logic                 ref_req_valid,
  output logic                 ref_req_ready,
  input  logic [BANK_BITS-1:0] ref_req_bank,
  output logic                 ref_rsp_valid,
  input  logic                 ref_rsp_ready,
  output logic [BANK_BITS-1:0] ref_rsp_bank,
  output logic [ROW_WIDTH-1:0] ref_rsp_row,
  output logic                 ref_rsp_dummy,
  output logic                 ref_rsp_wrap
`ifdef WUPR_BANK_TRACKER_STATS_EN
  ,
  output logic [31:0]          skip_cnt
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t               state_q;
  logic [OFF_BITS-1:0]  spr_q [N_BANK][N_SEG];
  logic [OFF_BITS-1:0]  spr_d [N_BANK][N_SEG];
  logic [ROW_WIDTH-1:0] rc_q  [N_BANK];
  logic [BANK_BITS-1:0] rsp_bank_q;
  logic [ROW_WIDTH-1:0] rsp_row_q;
  logic                 rsp_dummy_q;
  logic                 rsp_wrap_q;

  logic                 accept;
  logic [ROW_WIDTH-1:0] req_row;
  logic [SEG_BITS-1:0]  req_seg;
  logic [OFF_BITS-1:0]  req_off;
  logic [SEG_BITS-1:0]  wr_seg;
  logic [OFF_BITS-1:0]  wr_off;
  logic [OFF_BITS-1:0]  eff_peak;
  logic                 req_dummy;

  // Nothing is accepted while reset is held, so ready is masked by rst_n.
  assign ref_req_ready = rst_n && ((state_q == EMPTY) || ref_rsp_ready);
  assign accept        = ref_req_valid && ref_req_ready;

  assign wr_seg  = wr_row[ROW_WIDTH-1 -: SEG_BITS];
  assign wr_off  = wr_row[OFF_BITS-1:0];
  assign req_row = rc_q[ref_req_bank];
  assign req_seg = req_row[ROW_WIDTH-1 -: SEG_BITS];
  assign req_off = req_row[OFF_BITS-1:0];

  // Decision uses pre-clear peaks, with a same-cycle write forwarded in.
  always_comb begin
    eff_peak = spr_q[ref_req_bank][req_seg];
    if (wr_valid && (wr_bank == ref_req_bank) && (wr_seg == req_seg) && (wr_off > eff_peak))
      eff_peak = wr_off;
    req_dummy = (req_off > eff_peak);
  end

  // A write to a bank being cleared overwrites its segment rather than taking the max.
  always_comb begin
    spr_d = spr_q;
    for (int b = 0; b < N_BANK; b++) begin
      for (int s = 0; s < N_SEG; s++) begin
        if (wr_valid && (wr_bank == BANK_BITS'(b)) && (wr_seg == SEG_BITS'(s))) begin
          if ((clr_valid && (clr_bank == BANK_BITS'(b))) || (wr_off > spr_q[b][s]))
            spr_d[b][s] = wr_off;
        end else if (clr_valid && (clr_bank == BANK_BITS'(b))) begin
          spr_d[b][s] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < N_BANK; b++) begin
        rc_q[b] <= '0;
        for (int s = 0; s < N_SEG; s++)
          spr_q[b][s] <= '0;
      end
      state_q     <= EMPTY;
      rsp_bank_q  <= '0;
      rsp_row_q   <= '0;
      rsp_dummy_q <= 1'b0;
      rsp_wrap_q  <= 1'b0;
    end else begin
      spr_q <= spr_d;
      if (accept) begin
        rc_q[ref_req_bank] <= req_row + ROW_WIDTH'(1);
        state_q     <= FULL;
        rsp_bank_q  <= ref_req_bank;
        rsp_row_q   <= req_row;
        rsp_dummy_q <= req_dummy;
        rsp_wrap_q  <= (req_row == {ROW_WIDTH{1'b1}});
      end else if (ref_rsp_ready) begin
        state_q <= EMPTY;
      end
    end
  end

  assign ref_rsp_valid = (state_q == FULL);
  assign ref_rsp_bank  = rsp_bank_q;
  assign ref_rsp_row   = rsp_row_q;
  assign ref_rsp_dummy = rsp_dummy_q;
  assign ref_rsp_wrap  = rsp_wrap_q;

`ifdef WUPR_BANK_TRACKER_STATS_EN
  logic [31:0] skip_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      skip_cnt_q <= '0;
    else if (accept && req_dummy && (skip_cnt_q != 32'hFFFF_FFFF))
      skip_cnt_q <= skip_cnt_q + 32'd1;
  end

  assign skip_cnt = skip_cnt_q;
`endif

endmodule

// File: tb/tb_wupr_bank_tracker.sv
// Testbench for wupr_bank_tracker: directed vector table, handshake/reset sequences,
// randomized run against a behavioural model, and a full row-counter wrap.
module tb_wupr_bank_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrValid;
  logic [1:0]  wrBank;
  logic [15:0] wrRow;
  logic        clrValid;
  logic [1:0]  clrBank;
  logic        reqValid;
  logic        reqReady;
  logic [1:0]  reqBank;
  logic        rspValid;
  logic        rspReady;
  logic [1:0]  rspBank;
  logic [15:0] rspRow;
  logic        rspDummy;
  logic        rspWrap;
`ifdef WUPR_BANK_TRACKER_STATS_EN
  logic [31:0] skipCnt;
`endif

  int checksTotal  = 0;
  int checksPassed = 0;

  wupr_bank_tracker dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_valid      (wrValid),
    .wr_bank       (wrBank),
    .wr_row        (wrRow),
    .clr_valid     (clrValid),
    .clr_bank      (clrBank),
    .ref_req_valid (reqValid),
    .ref_req_ready (reqReady),
    .ref_req_bank  (reqBank),
    .ref_rsp_valid (rspValid),
    .ref_rsp_ready (rspReady),
    .ref_rsp_bank  (rspBank),
    .ref_rsp_row   (rspRow),
    .ref_rsp_dummy (rspDummy),
    .ref_rsp_wrap  (rspWrap)
`ifdef WUPR_BANK_TRACKER_STATS_EN
    ,
    .skip_cnt      (skipCnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        reqValid;
    logic [1:0]  reqBank;
    logic        wrValid;
    logic [1:0]  wrBank;
    logic [15:0] wrRow;
    logic        clrValid;
    logic [1:0]  clrBank;
    logic        expValid;
    logic [15:0] expRow;
    logic        expDummy;
    logic        expWrap;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual === expected)
      checksPassed++;
    else
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic rv, input logic [1:0] rb, input logic wv,
                               input logic [1:0] wb, input logic [15:0] wr,
                               input logic cv, input logic [1:0] cb, input logic rr);
    reqValid = rv; reqBank = rb;
    wrValid  = wv; wrBank  = wb; wrRow = wr;
    clrValid = cv; clrBank = cb;
    rspReady = rr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic rv, input logic [1:0] rb, input logic wv, input logic [1:0] wb,
                        input logic [15:0] wr, input logic cv, input logic [1:0] cb,
                        input logic ev, input logic [15:0] er, input logic ed, input logic ew);
    vec_t v;
    v = '{rv, rb, wv, wb, wr, cv, cb, ev, er, ed, ew};
    vecs.push_back(v);
  endtask

  // Behavioural model state for the randomized phase
  int          peak [4][16];
  int          rc   [4];
  bit          mFull;
  int          mBank, mRow;
  bit          mDummy, mWrap;
  int          mSkip;

  initial begin
    int tableDummies;
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 16'h0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", rspValid, 0);
    checkOutput("reset_row",   rspRow,   0);
    checkOutput("reset_bank",  rspBank,  0);
    checkOutput("reset_dummy", rspDummy, 0);
    checkOutput("reset_wrap",  rspWrap,  0);
    checkOutput("reset_ready", reqReady, 0);
    rst_n = 1'b1;
    #1;

    // rv rb wv wb row clr cb | expValid expRow expDummy expWrap
    addVec(1, 0, 0, 0, 16'h0000, 0, 0, 1, 16'd0, 0, 0);
    addVec(1, 0, 0, 0, 16'h0000, 0, 0, 1, 16'd1, 1, 0);
    addVec(1, 0, 0, 0, 16'h0000, 0, 0, 1, 16'd2, 1, 0);
    addVec(0, 0, 1, 1, 16'h0005, 0, 0, 0, 16'd0, 0, 0);
    for (int r = 0; r < 6; r++)
      addVec(1, 1, 0, 0, 16'h0000, 0, 0, 1, 16'(r), 0, 0);
    addVec(1, 1, 0, 0, 16'h0000, 0, 0, 1, 16'd6, 1, 0);
    addVec(1, 2, 0, 0, 16'h0000, 0, 0, 1, 16'd0, 0, 0);
    addVec(1, 2, 0, 0, 16'h0000, 0, 0, 1, 16'd1, 1, 0);
    addVec(1, 2, 0, 0, 16'h0000, 0, 0, 1, 16'd2, 1, 0);
    addVec(1, 2, 1, 2, 16'h0003, 0, 0, 1, 16'd3, 0, 0);
    addVec(0, 0, 1, 3, 16'h0FFF, 0, 0, 0, 16'd0, 0, 0);
    addVec(0, 0, 0, 0, 16'h0000, 1, 3, 0, 16'd0, 0, 0);
    addVec(1, 3, 0, 0, 16'h0000, 0, 0, 1, 16'd0, 0, 0);
    addVec(1, 3, 0, 0, 16'h0000, 0, 0, 1, 16'd1, 1, 0);
    addVec(0, 0, 1, 1, 16'h000A, 0, 0, 0, 16'd0, 0, 0);
    addVec(1, 1, 0, 0, 16'h0000, 1, 1, 1, 16'd7, 0, 0);
    addVec(1, 1, 0, 0, 16'h0000, 0, 0, 1, 16'd8, 1, 0);
    addVec(1, 1, 1, 1, 16'h0002, 1, 1, 1, 16'd9, 1, 0);
    addVec(0, 0, 1, 1, 16'h000C, 1, 1, 0, 16'd0, 0, 0);
    addVec(1, 1, 0, 0, 16'h0000, 0, 0, 1, 16'd10, 0, 0);
    addVec(0, 0, 1, 1, 16'h0001, 1, 1, 0, 16'd0, 0, 0);
    addVec(1, 1, 0, 0, 16'h0000, 0, 0, 1, 16'd11, 1, 0);
    addVec(1, 2, 1, 2, 16'h1007, 0, 0, 1, 16'd4, 1, 0);
    addVec(1, 2, 1, 0, 16'h0009, 0, 0, 1, 16'd5, 1, 0);

    tableDummies = 0;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].reqValid, vecs[i].reqBank, vecs[i].wrValid, vecs[i].wrBank,
                    vecs[i].wrRow, vecs[i].clrValid, vecs[i].clrBank, 1'b1);
      checkOutput($sformatf("vec%0d_ready", i), reqReady, 1);
      tick();
      checkOutput($sformatf("vec%0d_valid", i), rspValid, vecs[i].expValid);
      if (vecs[i].expValid) begin
        checkOutput($sformatf("vec%0d_bank", i),  rspBank,  vecs[i].reqBank);
        checkOutput($sformatf("vec%0d_row", i),   rspRow,   vecs[i].expRow);
        checkOutput($sformatf("vec%0d_dummy", i), rspDummy, vecs[i].expDummy);
        checkOutput($sformatf("vec%0d_wrap", i),  rspWrap,  vecs[i].expWrap);
        if (vecs[i].expDummy) tableDummies++;
      end
    end
`ifdef WUPR_BANK_TRACKER_STATS_EN
    checkOutput("table_skip_cnt", skipCnt, tableDummies);
`endif

    // Backpressure: decision must hold and no new request may be taken
    applyStimulus(0, 0, 0, 0, 16'h0, 0, 0, 1);
    tick();
    checkOutput("drain_valid", rspValid, 0);
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 0);
    checkOutput("bp_ready_empty", reqReady, 1);
    tick();
    checkOutput("bp_row_first", rspRow, 3);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 0);
      checkOutput($sformatf("bp_ready_hold%0d", c), reqReady, 0);
      tick();
      checkOutput($sformatf("bp_valid_hold%0d", c), rspValid, 1);
      checkOutput($sformatf("bp_row_hold%0d", c),   rspRow,   3);
      checkOutput($sformatf("bp_bank_hold%0d", c),  rspBank,  0);
      checkOutput($sformatf("bp_dummy_hold%0d", c), rspDummy, 0);
    end
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 1);
    checkOutput("bp_ready_release", reqReady, 1);
    tick();
    checkOutput("bp_row_next", rspRow, 4);
    checkOutput("bp_valid_next", rspValid, 1);

    // Reset in the middle of a pending handshake drops the decision
    applyStimulus(1, 1, 0, 0, 16'h0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ready", reqReady, 0);
    tick();
    checkOutput("midrst_valid", rspValid, 0);
    checkOutput("midrst_row",   rspRow,   0);
    rst_n = 1'b1;

    // Randomized run against the behavioural model
    foreach (rc[b]) begin
      rc[b] = 0;
      for (int s = 0; s < 16; s++) peak[b][s] = 0;
    end
    mFull = 0; mSkip = 0; mBank = 0; mRow = 0; mDummy = 0; mWrap = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit rv, wv, cv, rr, expReady;
      int rb, wb, cb, wseg, woff;
      rv = ($urandom_range(0, 3) != 0);
      rb = $urandom_range(0, 3);
      wv = ($urandom_range(0, 2) == 0);
      wb = $urandom_range(0, 3);
      wseg = $urandom_range(0, 1);
      woff = $urandom_range(0, 40);
      cv = ($urandom_range(0, 19) == 0);
      cb = $urandom_range(0, 3);
      rr = ($urandom_range(0, 3) != 0);
      applyStimulus(rv, 2'(rb), wv, 2'(wb), 16'(wseg * 4096 + woff), cv, 2'(cb), rr);
      expReady = !mFull || rr;
      checkOutput("rnd_ready", reqReady, expReady);
      if (rv && expReady) begin
        int row, seg, off, eff;
        row = rc[rb];
        seg = row / 4096;
        off = row % 4096;
        eff = peak[rb][seg];
        if (wv && wb == rb && wseg == seg && woff > eff) eff = woff;
        mDummy = (off > eff);
        mRow = row; mBank = rb; mWrap = (row == 65535);
        rc[rb] = (row + 1) % 65536;
        mFull = 1;
        if (mDummy) mSkip++;
      end else if (rr) begin
        mFull = 0;
      end
      if (cv) for (int s = 0; s < 16; s++) peak[cb][s] = 0;
      if (wv && woff > peak[wb][wseg]) peak[wb][wseg] = woff;
      tick();
      checkOutput("rnd_valid", rspValid, mFull);
      if (mFull) begin
        checkOutput("rnd_bank",  rspBank,  mBank);
        checkOutput("rnd_row",   rspRow,   mRow);
        checkOutput("rnd_dummy", rspDummy, mDummy);
        checkOutput("rnd_wrap",  rspWrap,  mWrap);
      end
    end
`ifdef WUPR_BANK_TRACKER_STATS_EN
    checkOutput("rnd_skip_cnt", skipCnt, mSkip);
`endif

    // Full row-counter wrap on bank 0 from a fresh reset
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 16'h0, 0, 0, 1);
    tick();
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 1);
    repeat (65535) @(posedge clk);
    #1;
    checkOutput("wrap_pre_row", rspRow, 16'hFFFE);
    tick();
    checkOutput("wrap_row",   rspRow,   16'hFFFF);
    checkOutput("wrap_flag",  rspWrap,  1);
    checkOutput("wrap_dummy", rspDummy, 1);
    tick();
    checkOutput("after_wrap_row",   rspRow,   0);
    checkOutput("after_wrap_flag",  rspWrap,  0);
    checkOutput("after_wrap_dummy", rspDummy, 0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/wupr_bank_tracker.md
WUPR_BANK_TRACKER -- requirements
Module: wupr_bank_tracker

Interface
REQ-001 The block SHALL have parameter ROW_WIDTH, default 16, row address width per bank.
REQ-002 The block SHALL have parameter N_SEG, default 16, power of 2, segments per bank; SEG_BITS = log2(N_SEG), OFF_BITS = ROW_WIDTH-SEG_BITS.
REQ-003 The block SHALL have parameter N_BANK, default 4, power of 2, banks tracked; BANK_BITS = max(1, log2(N_BANK)).
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 wr_valid  in  1  write command observed this cycle.
REQ-007 wr_bank  in  BANK_BITS  bank of write.
REQ-008 wr_row  in  ROW_WIDTH  row of write; upper SEG_BITS = segment, lower OFF_BITS = offset.
REQ-009 clr_valid  in  1  clear all segment peaks of clr_bank.
REQ-010 clr_bank  in  BANK_BITS  bank to clear.
REQ-011 ref_req_valid / ref_req_ready  in / out  1 / 1  refresh request handshake.
REQ-012 ref_req_bank  in  BANK_BITS  bank to refresh.
REQ-013 ref_rsp_valid / ref_rsp_ready  out / in  1 / 1  decision handshake.
REQ-014 ref_rsp_bank  out  BANK_BITS; ref_rsp_row  out  ROW_WIDTH; ref_rsp_dummy  out  1 (1 = dummy/skip, 0 = auto refresh); ref_rsp_wrap  out  1 (row was all-ones).

Function
REQ-015 Per bank b and segment s, the block SHALL hold peak register SPR[b][s] of OFF_BITS and a per-bank refresh counter RC[b] of ROW_WIDTH.
REQ-016 On wr_valid, SPR[wr_bank][seg] SHALL become max(SPR, offset) next cycle.
REQ-017 RC[b] SHALL advance only on an accepted request (ref_req_valid && ref_req_ready) for bank b, by +1 modulo 2^ROW_WIDTH; never free-running.
REQ-018 For an accepted request: row = RC[bank]; dummy = 1 iff row offset > effective peak; effective peak = SPR[bank][row seg], raised to wr offset if a write to the same bank/segment occurs in the same cycle (write forwarding; a written row is never skipped).
REQ-019 Latency: accept at cycle t -> ref_rsp_valid=1 with bank/row/dummy/wrap registered at t+1.
REQ-020 Output is a one-entry buffer, state EMPTY/FULL: EMPTY->FULL on accept; FULL->EMPTY on rsp_ready without new accept; FULL->FULL on rsp_ready with accept (back-to-back, one decision per cycle).
REQ-021 ref_req_ready = (state==EMPTY) || ref_rsp_ready (combinational pass-through).
REQ-022 While ref_rsp_valid && !ref_rsp_ready, all ref_rsp_* outputs SHALL hold stable.
REQ-023 clr_valid SHALL zero all SPR[clr_bank][*] next cycle; same-cycle write to clr_bank sets its segment to the write offset (write wins over clear).
REQ-024 Same-cycle clear and accepted request to same bank: decision uses pre-clear peaks (plus REQ-018 forwarding).
REQ-025 ref_rsp_wrap=1 iff issued row = 2^ROW_WIDTH-1; RC then wraps to 0; SPR unaffected by wrap.
REQ-026 Offset 0 SHALL always yield auto refresh (0 > peak never true).
REQ-027 Out-of-range bank indices (N_BANK not filling BANK_BITS) SHALL not occur (N_BANK is power of 2).

Reset
REQ-028 While rst_n=0 at a clk edge: all SPR=0, all RC=0, state EMPTY, ref_rsp_valid=0, ref_rsp_dummy=0, ref_rsp_wrap=0, ref_rsp_row=0, ref_rsp_bank=0.
REQ-029 Reset asserted mid-handshake SHALL drop the pending decision; no request accepted in a reset cycle.

Configuration
REQ-030 Macro WUPR_BANK_TRACKER_STATS_EN defined: extra output skip_cnt [31:0] counting accepted requests with dummy=1, saturating at 0xFFFFFFFF, reset to 0; undefined: port and counter absent, behaviour otherwise identical.

Verification
REQ-031 Reset; 3 requests bank 0, rsp_ready=1 -> rows 0,1,2; dummy 0,1,1.
REQ-032 Write bank1 row 0x0005; 7 requests bank1 -> rows 0..5 dummy=0, row 6 dummy=1.
REQ-033 Bank0 decision pending, rsp_ready=0 for 3 cycles -> outputs stable, req_ready=0, RC[0] unchanged; rsp_ready=1 -> next accept next cycle.
REQ-034 Bank2 requests rows 0-2, then request with same-cycle write bank2 row 0x0003 -> row 3 dummy=0.
REQ-035 Write bank3 row 0x0FFF, clr bank3, request bank3 twice -> row 0 dummy=0, row 1 dummy=1; with STATS_EN skip_cnt increments by 1.
REQ-036 65536 requests bank0 -> row 0xFFFF wrap=1, next row 0x0000 wrap=0.
